pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Consumer end of the hazard-detection interface. Turns per-cycle requests into per-stage pipeline-register
//  enables, flushes and PC-redirect selects: load-use stall (clk_stall, active-LOW), branch_kill, jump_kill.
//  Adds an external global hold (memory not ready), remembers kills raised during a hold, and keeps
//  saturating stall/flush counters plus a sticky stall-timeout flag. Sits between Hazard_Detection and the
//  IF/ID, ID/EX, EX/MEM, MEM/WB registers and the PC mux.
// PARAMETERS
//  CNT_W      16  width of stall_cnt / flush_cnt (saturating)
//  MAX_STALL  8   max consecutive load-use stall cycles before stall_timeout sets (>=1)
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      synchronous, active-high
//  clk_stall      in   1      0 = load-use stall request, 1 = none
//  branch_kill    in   1      taken branch resolved at EX/MEM
//  jump_kill      in   1      JAL/JALR in ID/EX
//  ext_hold       in   1      1 = freeze entire pipeline this cycle
//  pc_en          out  1      PC register load enable
//  if_id_en       out  1      IF/ID enable
//  id_ex_en       out  1      ID/EX enable
//  ex_mem_en      out  1      EX/MEM enable
//  mem_wb_en      out  1      MEM/WB enable
//  if_id_flush    out  1      load bubble into IF/ID
//  id_ex_flush    out  1      load bubble into ID/EX
//  pc_redirect    out  2      00 PC+4, 01 jump target, 10 branch target
//  state          out  2      last applied action: 0 RUN, 1 STALL, 2 FLUSH, 3 HOLD
//  stall_cnt      out  CNT_W  load-use stall cycles applied
//  flush_cnt      out  CNT_W  flush cycles applied
//  stall_timeout  out  1      sticky: load-use stall exceeded MAX_STALL consecutive cycles
// BEHAVIOUR
//  - Enables, flushes and pc_redirect are combinational from inputs and pending regs (same-cycle effect).
//  - While reset=1: all enables 0, if_id_flush=id_ex_flush=1, pc_redirect=00.
//    Next edge clears state=RUN, counters=0, stall_timeout=0, pend_branch=pend_jump=0, consec=0.
//  - eff_branch = branch_kill|pend_branch; eff_jump = jump_kill|pend_jump. Action priority:
//    1 HOLD   ext_hold=1: all enables 0, flushes 0, redirect 00.
//             pend_branch |= branch_kill; pend_jump |= jump_kill. consec frozen.
//    2 FLUSH  eff_branch: all enables 1, if_id_flush=id_ex_flush=1, redirect 10. Overrides jump and stall.
//    3 FLUSH  eff_jump: all enables 1, if_id_flush=1, id_ex_flush=0, redirect 01. Overrides stall.
//    4 STALL  clk_stall=0: pc_en=if_id_en=0, id_ex_en=ex_mem_en=mem_wb_en=1, id_ex_flush=1,
//             if_id_flush=0, redirect 00.
//    5 RUN    all enables 1, flushes 0, redirect 00.
//  - Pending regs clear at the edge of any non-HOLD cycle; each pending kill is applied exactly once.
//    If the same kill input is still high that cycle, it is a single flush, not two.
//  - state <= action of current cycle at each edge.
//  - flush_cnt +1 per FLUSH cycle; stall_cnt +1 per STALL cycle; both saturate at 2^CNT_W-1, no wrap.
//  - consec: +1 per STALL cycle; cleared on RUN/FLUSH; held on HOLD.
//    When a STALL cycle occurs with consec==MAX_STALL, stall_timeout sets at that edge and stays 1 until reset.
//  - Reset mid-hold discards pending kills. Reset overrides every input.
// TESTING
//  1 reset 2 cycles, then idle inputs (clk_stall=1) -> state=0, all en=1, flushes 0, counters 0, timeout 0.
//  2 clk_stall=0 for 1 cycle -> that cycle pc_en=0, if_id_en=0, id_ex_flush=1;
//    next cycle state=1, stall_cnt=1, en all 1.
//  3 branch_kill=1, jump_kill=1, clk_stall=0 same cycle -> if_id_flush=id_ex_flush=1, pc_en=1,
//    redirect=10; flush_cnt=1, stall_cnt=0, state=2.
//  4 ext_hold=1 for 3 cycles, jump_kill=1 only in 2nd -> all en 0, no flush during hold;
//    first post-hold cycle if_id_flush=1, redirect=01; following cycle redirect=00, flush_cnt=1.
//  5 MAX_STALL=8: clk_stall=0 for 9 consecutive cycles -> stall_timeout=1 from cycle 10,
//    stays 1 after clk_stall=1. Same with ext_hold=1 inserted mid-run -> still sets after 9 stall cycles.
//  6 CNT_W=4: 20 stall cycles -> stall_cnt=15 and holds; reset mid-sequence -> stall_cnt=0 next cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: turns load-use stall, branch/jump kill and global hold requests into pipeline enables, flushes and PC select.
// Latency: enables, flushes and redirect are combinational (same cycle); state, counters and timeout update at the next edge.
// Backpressure: ext_hold freezes every stage and banks kills raised meanwhile; banked kills are applied once after release.
module pipeline_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_stall,
  input  logic             branch_kill,
  input  logic             jump_kill,
  input  logic             ext_hold,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       pc_redirect,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_timeout
);

  // consec only needs to reach MAX_STALL; it saturates there.
  localparam int CW = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0]    CONSEC_MAX = CW'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } action_t;

  action_t       act;
  action_t       state_q;
  logic          pend_branch;
  logic          pend_jump;
  logic [CW-1:0] consec;

  logic eff_branch;
  logic eff_jump;

  assign eff_branch = branch_kill | pend_branch;
  assign eff_jump   = jump_kill | pend_jump;
  assign state      = state_q;

  // Pick this cycle's action by priority and drive the pipeline controls from it.
  always_comb begin
    act         = ST_RUN;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pc_redirect = 2'b00;
    if (reset) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ext_hold) begin
      act       = ST_HOLD;
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (eff_branch) begin
      act         = ST_FLUSH;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pc_redirect = 2'b10;
    end else if (eff_jump) begin
      act         = ST_FLUSH;
      if_id_flush = 1'b1;
      pc_redirect = 2'b01;
    end else if (!clk_stall) begin
      act         = ST_STALL;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Record the applied action, bank kills during hold, and maintain counters and the timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pend_branch   <= 1'b0;
      pend_jump     <= 1'b0;
      stall_cnt     <= '0;
      flush_cnt     <= '0;
      consec        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state_q <= act;
      // Any non-hold cycle consumes the banked kills, even if the live input is still high.
      if (act == ST_HOLD) begin
        pend_branch <= pend_branch | branch_kill;
        pend_jump   <= pend_jump | jump_kill;
      end else begin
        pend_branch <= 1'b0;
        pend_jump   <= 1'b0;
      end
      if (act == ST_FLUSH && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
      if (act == ST_STALL) begin
        if (stall_cnt != CNT_MAX) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
        if (consec == CONSEC_MAX) begin
          stall_timeout <= 1'b1;
        end else begin
          consec <= consec + 1'b1;
        end
      end else if (act != ST_HOLD) begin
        consec <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W     = 4;
  localparam int MAX_STALL = 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  // {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id_flush, id_ex_flush, redirect}
  localparam logic [8:0] C_RST  = 9'b00000_11_00;
  localparam logic [8:0] C_RUN  = 9'b11111_00_00;
  localparam logic [8:0] C_STL  = 9'b00111_01_00;
  localparam logic [8:0] C_HOLD = 9'b00000_00_00;
  localparam logic [8:0] C_BFL  = 9'b11111_11_10;
  localparam logic [8:0] C_JFL  = 9'b11111_10_01;

  logic clk = 1'b0;
  logic reset = 1'b1, clk_stall = 1'b1, branch_kill = 1'b0, jump_kill = 1'b0, ext_hold = 1'b0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
  logic [1:0] pc_redirect, state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic stall_timeout;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .reset(reset), .clk_stall(clk_stall), .branch_kill(branch_kill),
    .jump_kill(jump_kill), .ext_hold(ext_hold), .pc_en(pc_en), .if_id_en(if_id_en),
    .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .pc_redirect(pc_redirect),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers describing what has happened so far.
  bit m_known = 0;
  int m_state = 0, m_sc = 0, m_fc = 0, m_run = 0;
  bit m_to = 0, m_pb = 0, m_pj = 0;

  // DUT values sampled mid-cycle by the most recent cycle() call.
  logic [8:0] s_comb;
  logic [1:0] s_state;
  logic [CNT_W-1:0] s_sc, s_fc;
  logic s_to;

  typedef struct {
    logic r, cs, bk, jk, h;
    logic [8:0] comb;
    logic reg_chk;
    logic [1:0] st;
    logic [3:0] sc, fc;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, sample and compare against the model mid-cycle, advance the model, step past the edge.
  task automatic cycle(input logic r, input logic cs, input logic bk, input logic jk, input logic h);
    int a;
    logic [8:0] e;
    reset = r; clk_stall = cs; branch_kill = bk; jump_kill = jk; ext_hold = h;
    #2;
    s_comb  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, pc_redirect};
    s_state = state; s_sc = stall_cnt; s_fc = flush_cnt; s_to = stall_timeout;
    a = 0;
    if (r)                 e = C_RST;
    else if (h)          begin e = C_HOLD; a = 3; end
    else if (bk || m_pb) begin e = C_BFL;  a = 2; end
    else if (jk || m_pj) begin e = C_JFL;  a = 2; end
    else if (!cs)        begin e = C_STL;  a = 1; end
    else                   e = C_RUN;
    chk("model_comb", 32'(s_comb), 32'(e));
    if (m_known) begin
      chk("model_state", 32'(s_state), m_state);
      chk("model_stall_cnt", 32'(s_sc), m_sc);
      chk("model_flush_cnt", 32'(s_fc), m_fc);
      chk("model_timeout", 32'(s_to), 32'(m_to));
    end
    if (r) begin
      m_known = 1; m_state = 0; m_sc = 0; m_fc = 0; m_run = 0; m_to = 0; m_pb = 0; m_pj = 0;
    end else begin
      m_state = a;
      if (a == 3) begin
        m_pb = m_pb | bk; m_pj = m_pj | jk;
      end else begin
        m_pb = 0; m_pj = 0;
      end
      if (a == 2) m_fc = (m_fc + 1 > CNT_MAX) ? CNT_MAX : m_fc + 1;
      if (a == 1) begin
        if (m_run >= MAX_STALL) m_to = 1;
        m_sc = (m_sc + 1 > CNT_MAX) ? CNT_MAX : m_sc + 1;
        m_run++;
      end else if (a != 3) begin
        m_run = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mode;
    tbl[0]  = '{1,1,0,0,0, C_RST,  0, 0, 0, 0};
    tbl[1]  = '{1,1,0,0,0, C_RST,  1, 0, 0, 0};
    tbl[2]  = '{0,1,0,0,0, C_RUN,  1, 0, 0, 0};
    tbl[3]  = '{0,0,0,0,0, C_STL,  1, 0, 0, 0};
    tbl[4]  = '{0,1,0,0,0, C_RUN,  1, 1, 1, 0};
    tbl[5]  = '{1,1,0,0,0, C_RST,  1, 0, 1, 0};
    tbl[6]  = '{0,0,1,1,0, C_BFL,  1, 0, 0, 0};
    tbl[7]  = '{0,1,0,0,0, C_RUN,  1, 2, 0, 1};
    tbl[8]  = '{1,1,0,0,0, C_RST,  1, 0, 0, 1};
    tbl[9]  = '{0,1,0,0,1, C_HOLD, 1, 0, 0, 0};
    tbl[10] = '{0,1,0,1,1, C_HOLD, 1, 3, 0, 0};
    tbl[11] = '{0,1,0,0,1, C_HOLD, 1, 3, 0, 0};
    tbl[12] = '{0,1,0,0,0, C_JFL,  1, 3, 0, 0};
    tbl[13] = '{0,1,0,0,0, C_RUN,  1, 2, 0, 1};
    tbl[14] = '{0,1,1,1,1, C_HOLD, 1, 0, 0, 1};
    tbl[15] = '{0,1,0,1,0, C_BFL,  1, 3, 0, 1};
    tbl[16] = '{0,1,0,0,0, C_RUN,  1, 2, 0, 2};
    tbl[17] = '{0,0,0,0,0, C_STL,  1, 0, 0, 2};

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].r, tbl[i].cs, tbl[i].bk, tbl[i].jk, tbl[i].h);
      chk($sformatf("tbl%0d_comb", i), 32'(s_comb), 32'(tbl[i].comb));
      if (tbl[i].reg_chk) begin
        chk($sformatf("tbl%0d_state", i), 32'(s_state), 32'(tbl[i].st));
        chk($sformatf("tbl%0d_stall_cnt", i), 32'(s_sc), 32'(tbl[i].sc));
        chk($sformatf("tbl%0d_flush_cnt", i), 32'(s_fc), 32'(tbl[i].fc));
        chk($sformatf("tbl%0d_timeout", i), 32'(s_to), 32'd0);
      end
    end

    // Timeout: nine back-to-back stalls, flag visible from the tenth cycle and sticky.
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk($sformatf("to_run_pre%0d", i), 32'(s_to), 32'd0);
    end
    cycle(0, 1, 0, 0, 0);
    chk("to_set", 32'(s_to), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 0);
      chk($sformatf("to_sticky%0d", i), 32'(s_to), 32'd1);
    end

    // Same, with a hold splitting the stall run.
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk($sformatf("to_hold_pre%0d", i), 32'(s_to), 32'd0);
    end
    cycle(0, 1, 0, 0, 0);
    chk("to_hold_set", 32'(s_to), 32'd1);

    // Saturation of stall_cnt, then reset mid-run.
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("stall_cnt_sat", 32'(s_sc), 32'd15);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
    chk("stall_cnt_sat_hold", 32'(s_sc), 32'd15);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("stall_cnt_after_reset", 32'(s_sc), 32'd0);
    chk("timeout_after_reset", 32'(s_to), 32'd0);

    // Randomized traffic against the model; phases alternate between stall-heavy and kill/hold-heavy.
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) mode = $urandom_range(0, 2);
      cycle(($urandom_range(0, 199) == 0),
            (mode == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0),
            ($urandom_range(0, (mode == 2) ? 3 : 9) == 0),
            ($urandom_range(0, (mode == 2) ? 3 : 9) == 0),
            ($urandom_range(0, (mode == 2) ? 2 : 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
